// File: rtl/token_serializer_pkg.sv
// Shared attention-pipeline definitions: FSM encoding and token-slice sizing.
package token_serializer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   function automatic int unsigned tok_w(input int unsigned data_width,
                                         input int unsigned token_dim);
      return data_width * token_dim;
   endfunction

endpackage

// File: rtl/token_serializer_dff_en.sv
// Register primitive with load enable; clears asynchronously on active-low reset.
module dff_en #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/token_serializer.sv
// Buffers one attention frame and emits it token by token over a valid/ready stream.
module token_serializer
   import token_serializer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned TOKEN_DIM  = 4,
   parameter int unsigned TOKEN_NUM  = 8
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] frame_in,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   output logic [DATA_WIDTH*TOKEN_DIM-1:0]       tok_out,
   output logic [$clog2(TOKEN_NUM)-1:0]          tok_idx,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  out_last,
   output logic [15:0]                           frame_cnt
);

   localparam int unsigned TOK_W   = tok_w(DATA_WIDTH, TOKEN_DIM);
   localparam int unsigned FRAME_W = TOK_W * TOKEN_NUM;
   localparam int unsigned IDX_W   = $clog2(TOKEN_NUM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOKEN_NUM - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [IDX_W-1:0]   r_idx;
   logic [15:0]        r_frame_cnt;
   logic [FRAME_W-1:0] w_buf;
   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_last;
   logic               w_in_hs;
   logic               w_out_hs;

   dff_en #(
      .WIDTH (FRAME_W)
   ) u_frame_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_in_hs),
      .d     (frame_in),
      .q     (w_buf)
   );

   // in_ready in SEND depends on out_ready so a new frame can load on the
   // same edge the last token leaves, giving zero-bubble back-to-back frames.
   always_comb begin
      w_next_state = r_state;
      w_out_valid  = 1'b0;
      w_last       = 1'b0;
      w_in_ready   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_next_state = ST_SEND;
            end
         end
         ST_SEND: begin
            w_out_valid = 1'b1;
            w_last      = (r_idx == LAST_IDX);
            w_in_ready  = w_last && out_ready;
            if (w_last && out_ready && !in_valid) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign w_in_hs  = in_valid && w_in_ready;
   assign w_out_hs = w_out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (w_in_hs) begin
         r_idx <= '0;
      end else if (w_out_hs) begin
         r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt <= '0;
      end else if (w_out_hs && w_last) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign tok_out   = w_buf[r_idx*TOK_W +: TOK_W];
   assign tok_idx   = r_idx;
   assign out_valid = w_out_valid;
   assign out_last  = w_last;
   assign in_ready  = w_in_ready;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_token_serializer.sv
// Randomized and directed stimulus against a queue-based token stream model.
module tb_token_serializer;

   localparam int unsigned DW = 16;
   localparam int unsigned TD = 4;
   localparam int unsigned TN = 8;
   localparam int unsigned TW = DW * TD;
   localparam int unsigned FW = TW * TN;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [FW-1:0] frame_in;
   logic          in_valid;
   logic          in_ready;
   logic [TW-1:0] tok_out;
   logic [2:0]    tok_idx;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic [15:0]   frame_cnt;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Expected stream: every token still owed downstream, in emission order.
   logic [TW-1:0] q_dat[$];
   int unsigned   q_idx[$];
   logic [15:0]   m_cnt = 16'd0;

   token_serializer #(
      .DATA_WIDTH (DW),
      .TOKEN_DIM  (TD),
      .TOKEN_NUM  (TN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_in  (frame_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tok_out   (tok_out),
      .tok_idx   (tok_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [FW-1:0] pat(input logic [15:0] base);
      logic [FW-1:0] f;
      for (int i = 0; i < int'(TN); i++) begin
         f[i*TW +: TW] = {TD{base + 16'(i)}};
      end
      return f;
   endfunction

   function automatic logic [FW-1:0] rnd_frame();
      logic [FW-1:0] f;
      for (int i = 0; i < int'(FW / 32); i++) begin
         f[i*32 +: 32] = $urandom;
      end
      return f;
   endfunction

   // One clock: check outputs mid-cycle, then advance the model at the edge.
   task automatic cyc();
      logic          m_ov, m_last, m_rdy, hs_in, hs_out;
      logic [FW-1:0] fr;
      @(negedge clk);
      m_ov   = (q_dat.size() != 0);
      m_last = m_ov && (q_idx[0] == TN - 1);
      m_rdy  = !m_ov || (m_last && out_ready);
      check("in_ready", 64'(in_ready), 64'(m_rdy));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      check("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
      if (m_ov) begin
         check("tok_out", 64'(tok_out), 64'(q_dat[0]));
         check("tok_idx", 64'(tok_idx), 64'(q_idx[0]));
         check("out_last", 64'(out_last), 64'(m_last));
      end
      hs_in  = in_valid && m_rdy;
      hs_out = m_ov && out_ready;
      fr     = frame_in;
      @(posedge clk);
      if (hs_out) begin
         if (m_last) m_cnt = m_cnt + 16'd1;
         void'(q_dat.pop_front());
         void'(q_idx.pop_front());
      end
      if (hs_in) begin
         for (int i = 0; i < int'(TN); i++) begin
            q_dat.push_back(fr[i*TW +: TW]);
            q_idx.push_back(i);
         end
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   int unsigned valid_run;

   initial begin
      rst_n     = 1'b0;
      frame_in  = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_tok_idx", 64'(tok_idx), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("rst_buffer", 64'(tok_out), 64'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single frame, free-flowing output.
      frame_in = pat(16'h0100); in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      check("first_tok", 64'(tok_out), {4{16'h0100}});
      run(TN + 2);
      check("single_cnt", 64'(frame_cnt), 64'd1);

      // Back-pressure at token 3.
      frame_in = pat(16'h0100); in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      run(3);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("bp_tok", 64'(tok_out), {4{16'h0103}});
         check("bp_idx", 64'(tok_idx), 64'd3);
      end
      out_ready = 1'b1;
      run(TN);

      // Back-to-back A then B with in_valid held.
      frame_in = pat(16'h0200); in_valid = 1'b1;
      cyc();
      frame_in = pat(16'h0300);
      valid_run = 0;
      for (int i = 0; i < int'(TN); i++) begin
         if (out_valid) valid_run++;
         cyc();
      end
      in_valid = 1'b0;
      check("b2b_first_b", 64'(tok_out), {4{16'h0300}});
      for (int i = 0; i < int'(TN); i++) begin
         if (out_valid) valid_run++;
         cyc();
      end
      check("b2b_valid_run", 64'(valid_run), 64'(2 * TN));
      run(2);

      // Frame C offered mid-frame must be ignored.
      frame_in = pat(16'h0400); in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      run(2);
      frame_in = pat(16'h0500); in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      frame_in = '0;
      check("ign_tok", 64'(tok_out), {4{16'h0403}});
      run(TN);

      // Reset while token 5 is pending.
      frame_in = pat(16'h0600); in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      run(5);
      check("pre_rst_idx", 64'(tok_idx), 64'd5);
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("arst_tok_idx", 64'(tok_idx), 64'd0);
      q_dat.delete(); q_idx.delete(); m_cnt = 16'd0;
      #2 rst_n = 1'b1;
      frame_in = pat(16'h0700); in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      check("post_rst_idx", 64'(tok_idx), 64'd0);
      run(TN + 1);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         frame_in  = rnd_frame();
         in_valid  = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 9) < 7);
         cyc();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      run(2 * TN + 2);

      // Counter wrap from 0xFFFF.
      force dut.r_frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.r_frame_cnt;
      m_cnt = 16'hFFFF;
      @(posedge clk); #1;
      frame_in = rnd_frame(); in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      run(TN + 1);
      check("wrap_cnt", 64'(frame_cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
